// File: rtl/router_pkt_tx.sv
// Transmit end of the 1x3 router input protocol: buffers a whole payload, then sends
// header / payload / XOR parity to the router, honouring busy, and reports err afterwards.
module router_pkt_tx #(
  parameter int unsigned MAX_LEN  = 63,
  parameter int unsigned ERR_WAIT = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [1:0] req_addr_i,
  input  logic [5:0] req_len_i,
  input  logic       pl_valid_i,
  output logic       pl_ready_o,
  input  logic [7:0] pl_data_i,
  input  logic       busy_i,
  input  logic       err_i,
  output logic       pkt_valid_o,
  output logic [7:0] data_out_o,
  output logic       tx_active_o,
  output logic       tx_done_o,
  output logic       tx_err_o,
  output logic       illegal_req_o
);

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StHeader,
    StPayload,
    StParity,
    StErrWait
  } state_e;

  localparam int unsigned WaitW = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(ERR_WAIT - 1);
  localparam logic [5:0] MaxLenW = 6'(MAX_LEN);

  state_e           state_q, state_d;
  logic [1:0]       addr_q, addr_d;
  logic [5:0]       len_q, len_d;
  logic [5:0]       wr_cnt_q, wr_cnt_d;
  logic [5:0]       rd_cnt_q, rd_cnt_d;
  logic [7:0]       parity_q, parity_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_sticky_q, err_sticky_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_err_q, tx_err_d;
  logic             illegal_q, illegal_d;
  logic [7:0]       buf_q [MAX_LEN];
  logic             buf_we;
  logic             req_illegal;
  logic [7:0]       header;

  assign header      = {len_q, addr_q};
  assign req_illegal = (req_addr_i == 2'd3) || (req_len_i == 6'd0) || (req_len_i > MaxLenW);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    parity_d     = parity_q;
    wait_cnt_d   = wait_cnt_q;
    err_sticky_d = err_sticky_q;
    tx_done_d    = 1'b0;
    tx_err_d     = 1'b0;
    illegal_d    = 1'b0;
    buf_we       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          if (req_illegal) begin
            illegal_d = 1'b1;
          end else begin
            addr_d   = req_addr_i;
            len_d    = req_len_i;
            parity_d = {req_len_i, req_addr_i};
            wr_cnt_d = '0;
            state_d  = StFill;
          end
        end
      end
      StFill: begin
        if (pl_valid_i) begin
          buf_we   = 1'b1;
          parity_d = parity_q ^ pl_data_i;
          wr_cnt_d = wr_cnt_q + 6'd1;
          if (wr_cnt_q == len_q - 6'd1) state_d = StHeader;
        end
      end
      StHeader: begin
        if (!busy_i) begin
          rd_cnt_d = '0;
          state_d  = StPayload;
        end
      end
      StPayload: begin
        // busy freezes rd_cnt, which also covers the router's post-header stall
        if (!busy_i) begin
          if (rd_cnt_q == len_q - 6'd1) state_d = StParity;
          else                          rd_cnt_d = rd_cnt_q + 6'd1;
        end
      end
      StParity: begin
        if (!busy_i) begin
          wait_cnt_d   = '0;
          err_sticky_d = 1'b0;
          state_d      = StErrWait;
        end
      end
      StErrWait: begin
        err_sticky_d = err_sticky_q | err_i;
        if (wait_cnt_q == WaitLast) begin
          state_d   = StIdle;
          tx_done_d = 1'b1;
          tx_err_d  = err_sticky_q | err_i;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      len_q        <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      parity_q     <= '0;
      wait_cnt_q   <= '0;
      err_sticky_q <= 1'b0;
      tx_done_q    <= 1'b0;
      tx_err_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      parity_q     <= parity_d;
      wait_cnt_q   <= wait_cnt_d;
      err_sticky_q <= err_sticky_d;
      tx_done_q    <= tx_done_d;
      tx_err_q     <= tx_err_d;
      illegal_q    <= illegal_d;
    end
  end

  // Payload storage needs no reset; contents are only read after being written.
  always_ff @(posedge clock) begin
    if (buf_we) buf_q[wr_cnt_q] <= pl_data_i;
  end

  always_comb begin
    req_ready_o = (state_q == StIdle);
    pl_ready_o  = (state_q == StFill);
    pkt_valid_o = (state_q == StHeader) || (state_q == StPayload);
    tx_active_o = (state_q != StIdle);
    data_out_o  = '0;
    case (state_q)
      StHeader:  data_out_o = header;
      StPayload: data_out_o = buf_q[rd_cnt_q];
      StParity:  data_out_o = parity_q;
      default:   data_out_o = '0;
    endcase
  end

  assign tx_done_o     = tx_done_q;
  assign tx_err_o      = tx_err_q;
  assign illegal_req_o = illegal_q;

endmodule
